// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller: one 4-bit ripple slice per clock,
// LSB nibble first, with valid/ready handshakes on the operand and result sides.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [IW-1:0]    idx_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic [4:0]       c;
    logic             last;
    logic             accept;

    // 4-bit full-adder chain; c[3] is the carry into the slice MSB
    always_comb begin
        nib_a = a_q[int'(idx_q)*4 +: 4];
        nib_b = b_q[int'(idx_q)*4 +: 4];
        nib_s = '0;
        c     = '0;
        c[0]  = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_s[i] = nib_a[i] ^ nib_b[i] ^ c[i];
            c[i+1]   = (nib_a[i] & nib_b[i]) | (c[i] & (nib_a[i] ^ nib_b[i]));
        end
    end

    assign last   = (idx_q == IW'(NIB - 1));
    assign accept = (state == IDLE) && start_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start_valid) state_nx = RUN;
            RUN:  if (last)        state_nx = DONE;
            DONE: if (done_ready)  state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub | cin;
            idx_q   <= '0;
            s_q     <= '0;
        end else if (state == RUN) begin
            s_q[int'(idx_q)*4 +: 4] <= nib_s;
            carry_q <= c[4];
            idx_q   <= idx_q + IW'(1);
            if (last) begin
                cout_q <= c[4];
                ovf_q  <= c[3] ^ c[4];
            end
        end
    end

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);
    assign busy        = (state != IDLE);
    assign S           = s_q;
    assign Cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: WIDTH=16 and WIDTH=4 instances,
// expected results from a whole-word reference model via a scoreboard queue.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [15:0] S;
    logic        Cout;
    logic        ovf;
    logic        busy;

    logic        s4_valid = 1'b0;
    logic        s4_ready;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        cin4 = 1'b0;
    logic        d4_valid;
    logic        d4_ready = 1'b0;
    logic [3:0]  S4;
    logic        Cout4;
    logic        ovf4;
    logic        busy4;

    int          nvec = 0;
    int          nerr = 0;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .done_valid(done_valid), .done_ready(done_ready),
        .S(S), .Cout(Cout), .ovf(ovf), .busy(busy)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s4_valid), .start_ready(s4_ready),
        .a(a4), .b(b4), .cin(cin4), .sub(1'b0),
        .done_valid(d4_valid), .done_ready(d4_ready),
        .S(S4), .Cout(Cout4), .ovf(ovf4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci, input logic sb_);
        logic [15:0] yy;
        logic [16:0] sum;
        logic        v;
        yy  = sb_ ? ~y : y;
        sum = {1'b0, x} + {1'b0, yy} + {16'd0, (sb_ | ci)};
        v   = (x[15] == yy[15]) && (sum[15] != x[15]);
        return {v, sum[16], sum[15:0]};
    endfunction

    // Drive one operation, push its expectation, accept at the next edge
    task automatic start_op(input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic sb_);
        @(negedge clk);
        chk("start_ready_idle", 32'(start_ready), 32'd1);
        a = x; b = y; cin = ci; sub = sb_;
        start_valid = 1'b1;
        sb.push_back(model(x, y, ci, sb_));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_clears_S", 32'(S), 32'd0);
    endtask

    // Wait (bounded) for done_valid, check latency and pop the scoreboard
    task automatic finish_op(input string tag, input bit handshake);
        logic [17:0] e;
        int          lat;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        e = sb.pop_front();
        chk({tag, "_S"}, 32'(S), 32'(e[15:0]));
        chk({tag, "_Cout"}, 32'(Cout), 32'(e[16]));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e[17]));
        if (handshake) begin
            @(negedge clk);
            done_ready = 1'b1;
            @(posedge clk);
            #1;
            done_ready = 1'b0;
            chk({tag, "_ack_done_low"}, 32'(done_valid), 32'd0);
            chk({tag, "_hold_S"}, 32'(S), 32'(e[15:0]));
        end
    endtask

    initial begin
        logic [15:0] held;
        int          lat4;

        #12;
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_Cout_ovf", {30'd0, Cout, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        finish_op("t1_wrap", 1'b1);
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        finish_op("t2_sub_borrow", 1'b1);
        start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
        finish_op("t2_sub_noborrow", 1'b1);
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        finish_op("t3_pos_ovf", 1'b1);
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        finish_op("t3_neg_ovf", 1'b1);
        start_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        finish_op("t_mixed_add", 1'b1);

        // Stall in DONE while start_valid toggles
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        finish_op("t4_pre", 1'b0);
        held = S;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_valid = (i % 2 == 0);
            a = 16'h1111 * 16'(i + 1);
            b = 16'h0001;
            @(posedge clk);
            #1;
            chk("t4_done_held", 32'(done_valid), 32'd1);
            chk("t4_S_held", 32'(S), 32'(held));
            chk("t4_start_ready_low", 32'(start_ready), 32'd0);
        end
        @(negedge clk);
        done_ready = 1'b1;
        start_valid = 1'b1;
        a = 16'h4000; b = 16'h0123; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("t4_ack_to_idle", 32'(busy), 32'd0);
        chk("t4_idle_ready", 32'(start_ready), 32'd1);
        sb.push_back(model(16'h4000, 16'h0123, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("t4_next_accept", 32'(busy), 32'd1);
        finish_op("t4_next", 1'b1);

        // Reset mid-RUN at idx=2
        @(negedge clk);
        a = 16'h9999; b = 16'h6666; cin = 1'b1; sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_S", 32'(S), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done_valid), 32'd0);
        chk("t5_rst_flags", {30'd0, Cout, ovf}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'h1234, 16'h1111, 1'b1, 1'b0);
        finish_op("t5_after_rst", 1'b1);

        // WIDTH=4 instance, single RUN cycle
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        s4_valid = 1'b1;
        @(posedge clk);
        #1;
        s4_valid = 1'b0;
        lat4 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (d4_valid) begin
                lat4 = n;
                break;
            end
        end
        chk("t6_w4_latency", 32'(lat4), 32'd1);
        chk("t6_w4_S", 32'(S4), 32'hF);
        chk("t6_w4_Cout", 32'(Cout4), 32'd1);
        chk("t6_w4_ovf", 32'(ovf4), 32'd0);
        chk("t6_w4_busy", 32'(busy4), 32'd1);
        @(negedge clk);
        d4_ready = 1'b1;
        @(posedge clk);
        #1;
        d4_ready = 1'b0;
        chk("t6_w4_ack", 32'(s4_ready), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
